apb_slave_regbank: RTL and testbench

- APB peripheral downstream of bridge_top; consumes pselx/penable/pwrite/paddr/pwdata and returns prdata.
- One instance per pselx bit. Three instances populate the full peripheral map.
- Holds 14 read/write data words plus two read-only counters: committed writes and APB protocol errors.
- Tracks the APB setup/access sequence itself and rejects malformed transfers.

---
 rtl/apb_slave_pkg.sv | 16 +
 rtl/apb_slave_fsm.sv | 85 ++++++++
 rtl/apb_slave_regbank.sv | 95 +++++++++
 tb/tb_apb_slave_regbank.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared definitions for the APB slave register bank: phase encoding and
// the fixed word map (14 RW words followed by two read-only counters).
package apb_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    localparam logic [3:0] REG_WRCNT   = 4'd14;
    localparam logic [3:0] REG_ERRCNT  = 4'd15;
    localparam logic [3:0] LAST_RW_REG = 4'd13;
    localparam int         NUM_RW      = 14;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB phase tracker. Follows IDLE/SETUP/ACCESS, latches the setup-phase
// address/direction and flags reads to capture, writes to commit and
// malformed transfers to count.
module apb_slave_fsm
    import apb_slave_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sel,
    input  logic       i_penable,
    input  logic       i_pwrite,
    input  logic [3:0] i_off,
    output logic       o_rd_capture,
    output logic       o_wr_commit,
    output logic       o_err_pulse,
    output logic [3:0] o_addr_q,
    output logic       o_write_q
);

    apb_state_t r_state;
    apb_state_t w_state_nxt;
    logic [3:0] r_addr_q;
    logic       r_write_q;
    logic       w_capture;

    // Phase register plus the setup-phase captures
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_addr_q  <= 4'd0;
            r_write_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_addr_q  <= i_off;
                r_write_q <= i_pwrite;
            end
        end
    end

    // Next phase and per-edge event strobes; access must repeat the setup
    // address and direction or the transfer is dropped as an error
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        o_wr_commit = 1'b0;
        o_err_pulse = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_sel && !i_penable) begin
                    w_state_nxt = ST_SETUP;
                    w_capture   = 1'b1;
                end else if (i_sel && i_penable) begin
                    o_err_pulse = 1'b1;
                end
            end
            ST_SETUP: begin
                if (i_sel && i_penable) begin
                    w_state_nxt = ST_ACCESS;
                    if (i_off != r_addr_q || i_pwrite != r_write_q)
                        o_err_pulse = 1'b1;
                    else if (r_write_q)
                        o_wr_commit = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    o_err_pulse = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (i_sel && !i_penable) begin
                    w_state_nxt = ST_SETUP;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        o_rd_capture = w_capture && !i_pwrite;
    end

    assign o_addr_q  = r_addr_q;
    assign o_write_q = r_write_q;

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave with 14 RW words, a committed-write counter (word 14) and a
// protocol-error counter (word 15). Read data is sampled at the setup edge
// so it is stable for the whole access phase.
module apb_slave_regbank
    import apb_slave_pkg::*;
#(
    parameter int          SLV_IDX   = 0,
    parameter int          NREGS     = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [2:0]  pselx,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata
);

    logic [31:0] r_regs [NUM_RW];
    logic [31:0] r_wr_cnt;
    logic [31:0] r_err_cnt;
    logic [31:0] r_prdata;

    logic        w_sel;
    logic [3:0]  w_off;
    logic        w_rd_capture;
    logic        w_wr_commit;
    logic        w_err_pulse;
    logic [3:0]  w_addr_q;
    logic        w_write_q;
    logic        w_wr_en;
    logic [31:0] w_words [NREGS];
    logic        w_unused_bits;

    assign w_sel   = pselx[SLV_IDX];
    assign w_off   = paddr[5:2];
    // Only words 0..13 are writable; writes to the counters vanish quietly
    assign w_wr_en = w_wr_commit && (w_addr_q <= LAST_RW_REG);
    // Other selects and the undecoded address bits are deliberately ignored
    assign w_unused_bits = ^{pselx, paddr[31:6], paddr[1:0], w_write_q};

    apb_slave_fsm u_fsm (
        .i_clk        (hclk),
        .i_rst_n      (hresetn),
        .i_sel        (w_sel),
        .i_penable    (penable),
        .i_pwrite     (pwrite),
        .i_off        (w_off),
        .o_rd_capture (w_rd_capture),
        .o_wr_commit  (w_wr_commit),
        .o_err_pulse  (w_err_pulse),
        .o_addr_q     (w_addr_q),
        .o_write_q    (w_write_q)
    );

    // Flat view of the word map for the read mux
    always_comb begin
        for (int i = 0; i < NREGS; i++) w_words[i] = 32'd0;
        for (int i = 0; i < NUM_RW; i++) w_words[i] = r_regs[i];
        w_words[REG_WRCNT]  = r_wr_cnt;
        w_words[REG_ERRCNT] = r_err_cnt;
    end

    // RW storage, written at the access edge of a well-formed write
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < NUM_RW; i++) r_regs[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < NUM_RW; i++)
                if (w_wr_en && w_addr_q == 4'(i)) r_regs[i] <= pwdata;
        end
    end

    // Event counters; both free-run and wrap at 2^32
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_wr_cnt  <= 32'd0;
            r_err_cnt <= 32'd0;
        end else begin
            if (w_wr_en)     r_wr_cnt  <= r_wr_cnt + 32'd1;
            if (w_err_pulse) r_err_cnt <= r_err_cnt + 32'd1;
        end
    end

    // Read data register, loaded when a read setup is accepted
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)          r_prdata <= 32'd0;
        else if (w_rd_capture) r_prdata <= w_words[w_off];
    end

    assign prdata = r_prdata;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank (SLV_IDX = 0). Inputs change on the
// falling edge; outputs are sampled there too, away from the rising edge.
module tb_apb_slave_regbank;

    logic        hclk;
    logic        hresetn;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    int checks = 0;
    int errors = 0;

    apb_slave_regbank #(.SLV_IDX(0), .NREGS(16), .RESET_VAL(32'h0)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .pselx   (pselx),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic go_idle();
        @(negedge hclk);
        pselx   = 3'b000;
        penable = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge hclk);
        hresetn = 1'b0;
        pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0;
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
    endtask

    task automatic setup_ph(input logic [2:0] sel, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data);
        @(negedge hclk);
        pselx = sel; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    endtask

    task automatic access_ph();
        @(negedge hclk);
        penable = 1'b1;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        setup_ph(3'b001, 1'b1, addr, data);
        access_ph();
        go_idle();
    endtask

    // Returns prdata as seen during the access phase
    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        setup_ph(3'b001, 1'b0, addr, 32'h0);
        access_ph();
        data = prdata;
        go_idle();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++;
        if (prdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_prdata got %h exp %h", prdata, 32'h0);
        end
        for (int i = 0; i < 16; i++) begin
            apb_read(32'(i * 4), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_read[%0d] got %h exp %h", i, d, 32'h0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        do_reset();
        setup_ph(3'b001, 1'b1, 32'h08, 32'hDEAD_BEEF);
        access_ph();
        setup_ph(3'b001, 1'b0, 32'h08, 32'h0);
        access_ph();
        d = prdata;
        go_idle();
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL b2b_read got %h exp %h", d, 32'hDEAD_BEEF);
        end
        apb_read(32'h38, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL b2b_wrcnt got %h exp %h", d, 32'd1);
        end
    endtask

    task automatic test_ro_write();
        logic [31:0] d;
        do_reset();
        apb_write(32'h38, 32'h1234_5678);
        apb_read(32'h38, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL ro_wrcnt got %h exp %h", d, 32'd0);
        end
        apb_read(32'h3C, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL ro_errcnt got %h exp %h", d, 32'd0);
        end
    endtask

    task automatic test_malformed();
        logic [31:0] d;
        do_reset();
        // access phase with no setup
        @(negedge hclk);
        pselx = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h5555_5555;
        go_idle();
        apb_read(32'h3C, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL mal_nosetup_err got %h exp %h", d, 32'd1);
        end
        apb_read(32'h00, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL mal_nosetup_reg0 got %h exp %h", d, 32'd0);
        end
        // address changes between setup and access
        setup_ph(3'b001, 1'b1, 32'h04, 32'hCAFE_F00D);
        @(negedge hclk);
        penable = 1'b1; paddr = 32'h0C;
        go_idle();
        apb_read(32'h3C, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL mal_addr_err got %h exp %h", d, 32'd2);
        end
        apb_read(32'h04, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL mal_addr_reg1 got %h exp %h", d, 32'd0);
        end
        apb_read(32'h0C, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL mal_addr_reg3 got %h exp %h", d, 32'd0);
        end
        // abandoned setup
        setup_ph(3'b001, 1'b1, 32'h00, 32'h1111_1111);
        go_idle();
        apb_read(32'h3C, d);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL mal_drop_err got %h exp %h", d, 32'd3);
        end
        apb_read(32'h38, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL mal_wrcnt got %h exp %h", d, 32'd0);
        end
    endtask

    task automatic test_other_sel();
        logic [31:0] d;
        do_reset();
        apb_write(32'h08, 32'h0000_0011);
        apb_read(32'h08, d);
        checks++;
        if (d !== 32'h11) begin
            errors++;
            $display("FAIL osel_prep got %h exp %h", d, 32'h11);
        end
        setup_ph(3'b010, 1'b1, 32'h00, 32'hFFFF_FFFF);
        access_ph();
        checks++;
        if (prdata !== 32'h11) begin
            errors++;
            $display("FAIL osel_prdata got %h exp %h", prdata, 32'h11);
        end
        go_idle();
        apb_read(32'h00, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL osel_reg0 got %h exp %h", d, 32'h0);
        end
        apb_read(32'h3C, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL osel_errcnt got %h exp %h", d, 32'h0);
        end
    endtask

    task automatic test_reset_midxfer();
        logic [31:0] d;
        do_reset();
        apb_write(32'h14, 32'h0000_0077);
        apb_read(32'h14, d);
        checks++;
        if (d !== 32'h77) begin
            errors++;
            $display("FAIL mid_prep got %h exp %h", d, 32'h77);
        end
        setup_ph(3'b001, 1'b1, 32'h10, 32'hA5A5_A5A5);
        access_ph();
        #2 hresetn = 1'b0;
        #1;
        checks++;
        if (prdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_prdata got %h exp %h", prdata, 32'h0);
        end
        @(negedge hclk);
        hresetn = 1'b1; pselx = 3'b000; penable = 1'b0;
        apb_read(32'h10, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL mid_reg4 got %h exp %h", d, 32'h0);
        end
        apb_read(32'h38, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL mid_wrcnt got %h exp %h", d, 32'h0);
        end
        apb_read(32'h14, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL mid_reg5 got %h exp %h", d, 32'h0);
        end
    endtask

    initial begin
        hresetn = 1'b0;
        pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0;
        test_reset();
        test_back_to_back();
        test_ro_write();
        test_malformed();
        test_other_sel();
        test_reset_midxfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
